// File: rtl/ex_operand_issue.sv
// ID/EX pipeline register with the operand-forwarding front end for the ALU.
//
// Captures the decoded instruction from ID on each rising edge. It also:
//   - resolves RAW hazards by forwarding from EX/MEM (mem_*) and MEM/WB (wb_*),
//   - selects PC / immediate operands,
//   - stalls ID and bubbles EX on a load-use hazard,
//   - bubbles EX on a branch/jump flush.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   id_*               decoded instruction presented by ID
//   mem_*              EX/MEM destination, write enable and ALU result
//   wb_*               MEM/WB destination, write enable and writeback value
//   flush_i            redirect; the ID instruction is killed
//   operand_a_o/b_o    forwarded/selected ALU operands
//   alu_op_o           ALU operation of the EX instruction
//   ex_*               EX-stage instruction state passed down the pipe
//   stall_o            hold PC and the IF/ID register
module ex_operand_issue #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [RA_W-1:0] id_rs1_addr_i,
  input  logic [RA_W-1:0] id_rs2_addr_i,
  input  logic [RA_W-1:0] id_rd_addr_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [3:0]      id_alu_op_i,
  input  logic            id_asel_i,
  input  logic            id_bsel_i,
  input  logic            id_rd_wren_i,
  input  logic            id_mem_rden_i,
  input  logic [RA_W-1:0] mem_rd_addr_i,
  input  logic            mem_rd_wren_i,
  input  logic [XLEN-1:0] mem_alu_data_i,
  input  logic [RA_W-1:0] wb_rd_addr_i,
  input  logic            wb_rd_wren_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] operand_a_o,
  output logic [XLEN-1:0] operand_b_o,
  output logic [3:0]      alu_op_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [RA_W-1:0] ex_rd_addr_o,
  output logic            ex_rd_wren_o,
  output logic            ex_mem_rden_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic            stall_o
);

  localparam logic [3:0] AluAdd = 4'b0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            asel;
    logic            bsel;
    logic            rd_wren;
    logic            mem_rden;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  ex_reg_t bubble;

  logic            luse;
  logic            wb_hit_rs1, wb_hit_rs2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    bubble        = '0;
    bubble.alu_op = AluAdd;
  end

  // Load-use: both sources compared even if the ID instruction ignores rs2.
  assign luse = ex_q.valid && ex_q.mem_rden && (ex_q.rd_addr != '0) && id_valid_i &&
                ((ex_q.rd_addr == id_rs1_addr_i) || (ex_q.rd_addr == id_rs2_addr_i));

  assign stall_o = luse && !flush_i;

  // Capture-time bypass covers a register-file write landing in the same cycle as the read.
  assign wb_hit_rs1 = wb_rd_wren_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs1_addr_i);
  assign wb_hit_rs2 = wb_rd_wren_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs2_addr_i);

  always_comb begin
    ex_d = bubble;
    if (!flush_i && !luse && id_valid_i) begin
      ex_d.valid    = 1'b1;
      ex_d.pc       = id_pc_i;
      ex_d.rs1_addr = id_rs1_addr_i;
      ex_d.rs2_addr = id_rs2_addr_i;
      ex_d.rd_addr  = id_rd_addr_i;
      ex_d.rs1_data = wb_hit_rs1 ? wb_data_i : id_rs1_data_i;
      ex_d.rs2_data = wb_hit_rs2 ? wb_data_i : id_rs2_data_i;
      ex_d.imm      = id_imm_i;
      ex_d.alu_op   = id_alu_op_i;
      ex_d.asel     = id_asel_i;
      ex_d.bsel     = id_bsel_i;
      ex_d.rd_wren  = id_rd_wren_i;
      ex_d.mem_rden = id_mem_rden_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= bubble;
    end else begin
      ex_q <= ex_d;
    end
  end

  // EX-side forwarding; MEM beats WB, x0 always reads zero.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (ex_q.rs1_addr == '0) begin
      fwd_rs1 = '0;
    end else if (ex_q.valid && mem_rd_wren_i && (mem_rd_addr_i == ex_q.rs1_addr)) begin
      fwd_rs1 = mem_alu_data_i;
    end else if (ex_q.valid && wb_rd_wren_i && (wb_rd_addr_i == ex_q.rs1_addr)) begin
      fwd_rs1 = wb_data_i;
    end
  end

  always_comb begin
    fwd_rs2 = ex_q.rs2_data;
    if (ex_q.rs2_addr == '0) begin
      fwd_rs2 = '0;
    end else if (ex_q.valid && mem_rd_wren_i && (mem_rd_addr_i == ex_q.rs2_addr)) begin
      fwd_rs2 = mem_alu_data_i;
    end else if (ex_q.valid && wb_rd_wren_i && (wb_rd_addr_i == ex_q.rs2_addr)) begin
      fwd_rs2 = wb_data_i;
    end
  end

  assign operand_a_o     = ex_q.asel ? ex_q.pc : fwd_rs1;
  assign operand_b_o     = ex_q.bsel ? ex_q.imm : fwd_rs2;
  assign ex_store_data_o = fwd_rs2;
  assign alu_op_o        = ex_q.alu_op;
  assign ex_valid_o      = ex_q.valid;
  assign ex_pc_o         = ex_q.pc;
  assign ex_rd_addr_o    = ex_q.rd_addr;
  assign ex_rd_wren_o    = ex_q.rd_wren;
  assign ex_mem_rden_o   = ex_q.mem_rden;

endmodule

// File: tb/tb_ex_operand_issue.sv
module tb_ex_operand_issue;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [3:0]  id_alu_op_i;
  logic        id_asel_i, id_bsel_i, id_rd_wren_i, id_mem_rden_i;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_rd_wren_i;
  logic [31:0] mem_alu_data_i;
  logic [4:0]  wb_rd_addr_i;
  logic        wb_rd_wren_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic [31:0] operand_a_o, operand_b_o;
  logic [3:0]  alu_op_o;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_rd_wren_o, ex_mem_rden_o;
  logic [31:0] ex_store_data_o;
  logic        stall_o;

  int checks   = 0;
  int failures = 0;

  ex_operand_issue #(.XLEN(32), .RA_W(5)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_valid_i      (id_valid_i),
    .id_pc_i         (id_pc_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rd_addr_i    (id_rd_addr_i),
    .id_rs1_data_i   (id_rs1_data_i),
    .id_rs2_data_i   (id_rs2_data_i),
    .id_imm_i        (id_imm_i),
    .id_alu_op_i     (id_alu_op_i),
    .id_asel_i       (id_asel_i),
    .id_bsel_i       (id_bsel_i),
    .id_rd_wren_i    (id_rd_wren_i),
    .id_mem_rden_i   (id_mem_rden_i),
    .mem_rd_addr_i   (mem_rd_addr_i),
    .mem_rd_wren_i   (mem_rd_wren_i),
    .mem_alu_data_i  (mem_alu_data_i),
    .wb_rd_addr_i    (wb_rd_addr_i),
    .wb_rd_wren_i    (wb_rd_wren_i),
    .wb_data_i       (wb_data_i),
    .flush_i         (flush_i),
    .operand_a_o     (operand_a_o),
    .operand_b_o     (operand_b_o),
    .alu_op_o        (alu_op_o),
    .ex_valid_o      (ex_valid_o),
    .ex_pc_o         (ex_pc_o),
    .ex_rd_addr_o    (ex_rd_addr_o),
    .ex_rd_wren_o    (ex_rd_wren_o),
    .ex_mem_rden_o   (ex_mem_rden_o),
    .ex_store_data_o (ex_store_data_o),
    .stall_o         (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_idle();
    id_valid_i = 0; id_pc_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0;
    id_rd_addr_i = '0; id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0;
    id_alu_op_i = AluAdd; id_asel_i = 0; id_bsel_i = 0; id_rd_wren_i = 0; id_mem_rden_i = 0;
  endtask

  task automatic fwd_idle();
    mem_rd_addr_i = '0; mem_rd_wren_i = 0; mem_alu_data_i = '0;
    wb_rd_addr_i = '0; wb_rd_wren_i = 0; wb_data_i = '0;
  endtask

  // Present a load "lw rd, imm(x0)" on ID.
  task automatic id_load(input logic [4:0] rd, input logic [31:0] pc);
    id_idle();
    id_valid_i = 1; id_pc_i = pc; id_rd_addr_i = rd; id_imm_i = 32'd4;
    id_bsel_i = 1; id_rd_wren_i = 1; id_mem_rden_i = 1;
  endtask

  // Present an R-type "op rd, rs1, rs2" on ID.
  task automatic id_rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] op);
    id_idle();
    id_valid_i = 1; id_pc_i = 32'h180; id_rd_addr_i = rd; id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2; id_rs1_data_i = d1; id_rs2_data_i = d2; id_alu_op_i = op;
    id_rd_wren_i = 1;
  endtask

  initial begin
    rst_i = 1; flush_i = 0;
    id_idle(); fwd_idle();
    // Put non-reset values in first so reset has something to clear.
    id_rtype(5'd9, 5'd1, 5'd2, 32'h3, 32'h4, AluSub);
    rst_i = 0;
    step();
    rst_i = 1;
    step();
    rst_i = 0;
    id_idle();
    #1;
    check("rst_valid", 32'(ex_valid_o), 32'd0);
    check("rst_opa", operand_a_o, 32'd0);
    check("rst_opb", operand_b_o, 32'd0);
    check("rst_aluop", 32'(alu_op_o), 32'(AluAdd));
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_wren", 32'(ex_rd_wren_o), 32'd0);
    check("rst_pc", ex_pc_o, 32'd0);

    // addi x1, x0, 5
    id_valid_i = 1; id_pc_i = 32'h100; id_rd_addr_i = 5'd1; id_imm_i = 32'd5;
    id_bsel_i = 1; id_rd_wren_i = 1;
    step();
    id_idle();
    #1;
    check("addi_valid", 32'(ex_valid_o), 32'd1);
    check("addi_opa", operand_a_o, 32'd0);
    check("addi_opb", operand_b_o, 32'd5);
    check("addi_aluop", 32'(alu_op_o), 32'(AluAdd));
    check("addi_pc", ex_pc_o, 32'h100);
    check("addi_rd", 32'(ex_rd_addr_o), 32'd1);
    check("addi_wren", 32'(ex_rd_wren_o), 32'd1);

    // sub x4, x1, x0 with x1 = 5 in the register file; MEM beats WB beats register.
    id_rtype(5'd4, 5'd1, 5'd0, 32'd5, 32'd0, AluSub);
    step();
    id_idle();
    mem_rd_addr_i = 5'd1; mem_rd_wren_i = 1; mem_alu_data_i = 32'h10;
    wb_rd_addr_i = 5'd1; wb_rd_wren_i = 1; wb_data_i = 32'h20;
    #1;
    check("fwd_mem_prio", operand_a_o, 32'h10);
    check("fwd_aluop", 32'(alu_op_o), 32'(AluSub));
    mem_rd_wren_i = 0;
    #1;
    check("fwd_wb", operand_a_o, 32'h20);
    wb_rd_wren_i = 0;
    #1;
    check("fwd_none", operand_a_o, 32'd5);
    // x0 is never forwarded, even with a live write targeting it.
    mem_rd_addr_i = 5'd0; mem_rd_wren_i = 1; mem_alu_data_i = 32'hFFFF_FFFF;
    wb_rd_addr_i = 5'd0; wb_rd_wren_i = 1; wb_data_i = 32'hFFFF_FFFF;
    #1;
    check("x0_rs2_opb", operand_b_o, 32'd0);
    check("x0_rs2_store", ex_store_data_o, 32'd0);
    // add x6, x0, x0 captured while MEM/WB still target x0.
    id_rtype(5'd6, 5'd0, 5'd0, 32'd0, 32'd0, AluAdd);
    step();
    id_idle();
    #1;
    check("x0_opa", operand_a_o, 32'd0);
    check("x0_opb", operand_b_o, 32'd0);
    fwd_idle();

    // lw x2 followed by dependent add x3, x2, x2.
    id_load(5'd2, 32'h200);
    step();
    id_rtype(5'd3, 5'd2, 5'd2, 32'h1, 32'h1, AluAdd);
    #1;
    check("luse_ex_load", 32'(ex_mem_rden_o), 32'd1);
    check("luse_stall", 32'(stall_o), 32'd1);
    step();
    check("luse_bubble_valid", 32'(ex_valid_o), 32'd0);
    check("luse_bubble_wren", 32'(ex_rd_wren_o), 32'd0);
    check("luse_stall_drop", 32'(stall_o), 32'd0);
    step();
    id_idle();
    wb_rd_addr_i = 5'd2; wb_rd_wren_i = 1; wb_data_i = 32'hAB;
    #1;
    check("luse_add_valid", 32'(ex_valid_o), 32'd1);
    check("luse_opa", operand_a_o, 32'hAB);
    check("luse_opb", operand_b_o, 32'hAB);
    check("luse_store", ex_store_data_o, 32'hAB);
    check("luse_rd", 32'(ex_rd_addr_o), 32'd3);
    fwd_idle();

    // Same hazard under a flush: flush wins, add not captured.
    id_load(5'd2, 32'h240);
    step();
    id_rtype(5'd3, 5'd2, 5'd2, 32'h1, 32'h1, AluAdd);
    flush_i = 1;
    #1;
    check("flush_stall", 32'(stall_o), 32'd0);
    step();
    flush_i = 0;
    id_idle();
    #1;
    check("flush_valid", 32'(ex_valid_o), 32'd0);
    check("flush_wren", 32'(ex_rd_wren_o), 32'd0);
    check("flush_rd", 32'(ex_rd_addr_o), 32'd0);

    // Capture-time WB bypass on rs2 = x7, plus PC select on operand A.
    id_rtype(5'd8, 5'd0, 5'd7, 32'd0, 32'h11, AluAdd);
    id_asel_i = 1; id_pc_i = 32'h300;
    wb_rd_addr_i = 5'd7; wb_rd_wren_i = 1; wb_data_i = 32'h77;
    step();
    id_idle(); fwd_idle();
    #1;
    check("cap_wb_opb", operand_b_o, 32'h77);
    check("cap_wb_store", ex_store_data_o, 32'h77);
    check("asel_pc", operand_a_o, 32'h300);

    // Reset while a stall is pending drops it.
    id_load(5'd5, 32'h400);
    step();
    id_rtype(5'd9, 5'd5, 5'd0, 32'd0, 32'd0, AluAdd);
    #1;
    check("midstall_stall", 32'(stall_o), 32'd1);
    rst_i = 1;
    step();
    rst_i = 0;
    #1;
    check("midstall_rst_stall", 32'(stall_o), 32'd0);
    check("midstall_rst_valid", 32'(ex_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_operand_issue.md
Name: ex_operand_issue

Overview:
- ID/EX pipeline register plus operand-forwarding front end that drives the ALU's operand_a, operand_b and alu_op inputs in the forwarding pipeline.
- Captures decoded instructions from ID, resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and selects PC or immediate operands.
- Detects load-use hazards: stalls ID and inserts a bubble into EX.
- Handles branch flushes by bubbling EX.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
id_valid_i  in  1  ID slot holds a real instruction
id_pc_i  in  XLEN  PC of ID instruction
id_rs1_addr_i  in  RA_W  source 1 index
id_rs2_addr_i  in  RA_W  source 2 index
id_rd_addr_i  in  RA_W  destination index
id_rs1_data_i  in  XLEN  register file read port 1
id_rs2_data_i  in  XLEN  register file read port 2
id_imm_i  in  XLEN  sign-extended immediate
id_alu_op_i  in  4  ALU operation code (shared constants file encoding)
id_asel_i  in  1  0=rs1, 1=PC
id_bsel_i  in  1  0=rs2, 1=imm
id_rd_wren_i  in  1  instruction writes rd
id_mem_rden_i  in  1  instruction is a load
mem_rd_addr_i  in  RA_W  EX/MEM destination
mem_rd_wren_i  in  1  EX/MEM writes rd
mem_alu_data_i  in  XLEN  EX/MEM ALU result
wb_rd_addr_i  in  RA_W  MEM/WB destination
wb_rd_wren_i  in  1  MEM/WB writes rd
wb_data_i  in  XLEN  MEM/WB writeback value
flush_i  in  1  branch/jump redirect; kill ID instruction
operand_a_o  out  XLEN  to ALU operand_a
operand_b_o  out  XLEN  to ALU operand_b
alu_op_o  out  4  to ALU alu_op
ex_valid_o  out  1  EX instruction valid
ex_pc_o  out  XLEN  EX PC
ex_rd_addr_o  out  RA_W  EX destination
ex_rd_wren_o  out  1  EX write enable (0 for bubbles)
ex_mem_rden_o  out  1  EX is a load
ex_store_data_o  out  XLEN  forwarded rs2 value (store data)
stall_o  out  1  hold PC and IF/ID register

Behaviour:
- Reset (rst_i=1 at an edge):
  - All EX register fields cleared: valid, rd_wren and mem_rden = 0; pc, rd and data = 0.
  - alu_op = ADD code.
  - With no forwarding match, outputs read operand_a_o = operand_b_o = 0 and stall_o = 0 the cycle after.
  - Reset mid-stall drops the stall.
- Latency: ID fields captured at the edge; visible on outputs one cycle later. Forward muxes are combinational from the EX register and the mem_/wb_ inputs.
- Capture-time WB bypass:
  - On capture, if wb_rd_wren_i, wb_rd_addr_i != 0 and wb_rd_addr_i == id_rsX_addr_i, the register stores wb_data_i instead of id_rsX_data_i.
  - This covers a same-cycle register file write.
- EX-side forwarding per source X (rs1, rs2), in priority order:
  1. mem_rd_wren_i && mem_rd_addr_i != 0 && mem_rd_addr_i == ex_rsX gives mem_alu_data_i.
  2. Otherwise wb_rd_wren_i && wb_rd_addr_i != 0 && match gives wb_data_i.
  3. Otherwise the registered value.
  - x0 is never forwarded and always reads 0.
  - Forwarding is applied only when ex_valid_o=1.
- Operand selection:
  - operand_a_o = asel ? ex_pc : fwd_rs1.
  - operand_b_o = bsel ? ex_imm : fwd_rs2.
  - ex_store_data_o = fwd_rs2 regardless of bsel.
- Load-use detection:
  - luse = ex_valid && ex_mem_rden && ex_rd != 0 && id_valid_i && (ex_rd == id_rs1 || ex_rd == id_rs2).
  - Compares both sources conservatively.
  - stall_o = luse && !flush_i.
- Next EX register state, in priority order:
  1. rst_i: reset values.
  2. flush_i: bubble.
  3. luse: bubble. ID holds and re-presents next cycle, when the load is in MEM/WB and forwards via the wb path.
  4. Otherwise: capture ID. If id_valid_i=0, a bubble.
- Bubble: valid=0, rd_wren=0, mem_rden=0, alu_op=ADD, rs addresses=0. Data fields are don't-care but are driven to 0.
- Simultaneous flush and luse: flush wins; stall_o=0.
- A stall lasts exactly one cycle per load; back-to-back dependent loads each stall once.

Test Plan:
- Reset, then capture addi x1,x0,5 (bsel=1, imm=5) → next cycle operand_a_o=0, operand_b_o=5, alu_op_o=ADD, ex_valid_o=1.
- EX reads x1 (reg=5) with mem_rd_addr_i=1, mem_alu_data_i=0x10 and wb targeting x1 with 0x20 → operand_a_o=0x10 (MEM priority). Drop the MEM match → 0x20.
- lw x2 in EX, then ID add x3,x2,x2 → stall_o=1 one cycle, next ex_valid_o=0. Following cycle wb_data_i=0xAB for x2 → operand_a_o=operand_b_o=0xAB.
- Same load-use case with flush_i=1 → stall_o=0, EX bubble, add not captured.
- mem/wb writes to x0 with data 0xFFFF_FFFF while EX reads x0 → operands remain 0.
- Capture while wb_rd_wren_i=1, wb_rd_addr_i=rs2=7, wb_data_i=0x77, regfile data 0x11 → next cycle, with no forwarding active, operand_b_o=0x77.
